fp_window_reducer: RTL and testbench

FP_WINDOW_REDUCER -- requirements
Module: fp_window_reducer

---
 rtl/fp_window_reducer.sv | 191 +++++++++++++++++++
 tb/tb_fp_window_reducer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fp_window_reducer.sv
// fp_window_reducer: reduces WINDOW single-precision samples to one result
// by sum (round-to-nearest-even) or max, with a one-entry output handshake.
module fp_window_reducer #(
  parameter int WINDOW = 4,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_i,
  input  logic [31:0] num_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] sum_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [31:0]        acc;
  logic               op_q;
  logic [31:0]        flushed;
  logic [31:0]        step;

  // Denormals become zero of the same sign.
  function automatic logic [31:0] flush_dn(input logic [31:0] x);
    flush_dn = (x[30:23] == 8'd0) ? {x[31], 31'd0} : x;
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    is_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // Single-precision add of two flushed operands, RNE with guard/round/sticky.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big;
    logic [31:0] sml;
    logic [7:0]  d8;
    logic [49:0] wide;
    logic [26:0] xb;
    logic [26:0] xs;
    logic [27:0] acc28;
    logic [26:0] diff;
    logic [26:0] m;
    logic [24:0] rnd;
    logic [22:0] frac;
    logic        up;
    logic        zero_res;
    logic        found;
    int          lz;
    int          e;
    logic [31:0] res;
    res      = QNAN;
    big      = a;
    sml      = b;
    wide     = '0;
    xs       = '0;
    acc28    = '0;
    diff     = '0;
    m        = '0;
    zero_res = 1'b0;
    found    = 1'b0;
    lz       = 0;
    if (is_nan(a) || is_nan(b)) begin
      res = QNAN;
    end else if (is_inf(a) && is_inf(b)) begin
      res = (a[31] == b[31]) ? a : QNAN;
    end else if (is_inf(a)) begin
      res = a;
    end else if (is_inf(b)) begin
      res = b;
    end else if ((a[30:23] == 8'd0) && (b[30:23] == 8'd0)) begin
      res = {a[31] & b[31], 31'd0};
    end else if (a[30:23] == 8'd0) begin
      res = b;
    end else if (b[30:23] == 8'd0) begin
      res = a;
    end else begin
      if (a[30:0] < b[30:0]) begin
        big = b;
        sml = a;
      end
      d8 = big[30:23] - sml[30:23];
      xb = {1'b1, big[22:0], 3'b000};
      if (d8 >= 8'd26) begin
        xs = 27'd1;
      end else begin
        wide = {1'b1, sml[22:0], 26'd0} >> d8;
        xs   = {wide[49:24], |wide[23:0]};
      end
      e = int'(big[30:23]);
      if (big[31] == sml[31]) begin
        acc28 = {1'b0, xb} + {1'b0, xs};
        if (acc28[27]) begin
          m = {acc28[27:2], acc28[1] | acc28[0]};
          e = e + 1;
        end else begin
          m = acc28[26:0];
        end
      end else begin
        diff = xb - xs;
        if (diff == 27'd0) begin
          zero_res = 1'b1;
        end else begin
          for (int i = 26; i >= 0; i--) begin
            if (!found) begin
              if (diff[i]) found = 1'b1;
              else lz = lz + 1;
            end
          end
          m = diff << lz;
          e = e - lz;
        end
      end
      up   = m[2] & (m[1] | m[0] | m[3]);
      rnd  = {1'b0, m[26:3]} + 25'(up);
      e    = e + int'(rnd[24]);
      frac = rnd[24] ? rnd[23:1] : rnd[22:0];
      if (zero_res || e <= 0) res = 32'd0;
      else if (e >= 255) res = {big[31], 8'hFF, 23'd0};
      else res = {big[31], 8'(e), frac};
    end
    fp_add = res;
  endfunction

  // Max of two flushed operands; +0 ranks above -0, NaN canonicalised.
  function automatic logic [31:0] fp_max(input logic [31:0] a, input logic [31:0] b);
    logic a_gt_b;
    if (a[31] != b[31]) a_gt_b = b[31];
    else if (a[31]) a_gt_b = (a[30:0] < b[30:0]);
    else a_gt_b = (a[30:0] > b[30:0]);
    if (is_nan(a) || is_nan(b)) fp_max = QNAN;
    else fp_max = a_gt_b ? a : b;
  endfunction

  assign ready_o = (state == ACCUM) && !reset;

  // Next accumulator value for an accepted sample.
  always_comb begin
    flushed = flush_dn(num_i);
    step    = flushed;
    if (count == '0) step = is_nan(flushed) ? QNAN : flushed;
    else if (op_q) step = fp_max(acc, flushed);
    else step = fp_add(acc, flushed);
  end

  // Control FSM, window counter, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ACCUM;
      count   <= '0;
      acc     <= 32'd0;
      op_q    <= 1'b0;
      sum_o   <= 32'd0;
      valid_o <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (valid_i) begin
            acc <= step;
            if (count == '0) op_q <= op_i;
            if (count == CNT_W'(WINDOW - 1)) begin
              count   <= '0;
              sum_o   <= step;
              valid_o <= 1'b1;
              state   <= HOLD;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_window_reducer.sv
// Directed bench: WINDOW=4 (idx 0), WINDOW=2 (idx 1), WINDOW=1 (idx 2).
module tb_fp_window_reducer;

  logic        clk;
  logic        reset;
  logic        vi  [3];
  logic        opi [3];
  logic        rdi [3];
  logic        ro  [3];
  logic        vo  [3];
  logic [31:0] ni  [3];
  logic [31:0] so  [3];

  int checks;
  int errors;

  fp_window_reducer #(.WINDOW(4)) u_w4 (
    .clk(clk), .reset(reset), .op_i(opi[0]), .num_i(ni[0]), .valid_i(vi[0]),
    .ready_o(ro[0]), .sum_o(so[0]), .valid_o(vo[0]), .ready_i(rdi[0])
  );

  fp_window_reducer #(.WINDOW(2)) u_w2 (
    .clk(clk), .reset(reset), .op_i(opi[1]), .num_i(ni[1]), .valid_i(vi[1]),
    .ready_o(ro[1]), .sum_o(so[1]), .valid_o(vo[1]), .ready_i(rdi[1])
  );

  fp_window_reducer #(.WINDOW(1)) u_w1 (
    .clk(clk), .reset(reset), .op_i(opi[2]), .num_i(ni[2]), .valid_i(vi[2]),
    .ready_o(ro[2]), .sum_o(so[2]), .valid_o(vo[2]), .ready_i(rdi[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Present one sample at a negedge; it is accepted on the following posedge.
  task automatic send(input int k, input logic op, input logic [31:0] num);
    chk($sformatf("ready_%0d", k), 32'(ro[k]), 32'd1);
    vi[k]  = 1'b1;
    opi[k] = op;
    ni[k]  = num;
    @(negedge clk);
    vi[k]  = 1'b0;
  endtask

  // Result must be visible now; with ready_i=1 it is released on the next edge.
  task automatic result(input int k, input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, 32'(vo[k]), 32'd1);
    chk(tag, so[k], exp);
    @(negedge clk);
  endtask

  task automatic pair(input string tag, input logic op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    send(1, op, a);
    chk({tag, "_early"}, 32'(vo[1]), 32'd0);
    send(1, 1'b0, b);
    result(1, tag, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vi[k] = 1'b0; opi[k] = 1'b0; ni[k] = 32'd0; rdi[k] = 1'b1;
    end
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_sum", so[0], 32'd0);
    chk("rst_valid", 32'(vo[0]), 32'd0);
    chk("rst_ready", 32'(ro[0]), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(ro[0]), 32'd1);
    @(negedge clk);

    // Sum window: 1.5 + 2.25 - 0.75 + 4.0 = 7.0
    send(0, 1'b0, 32'h3FC00000);
    send(0, 1'b0, 32'h40100000);
    send(0, 1'b0, 32'hBF400000);
    chk("sum_early", 32'(vo[0]), 32'd0);
    send(0, 1'b0, 32'h40800000);
    chk("sum_ready_in_hold", 32'(ro[0]), 32'd0);
    result(0, "sum", 32'h40E00000);

    // Max with op latched from the first sample only
    send(0, 1'b1, 32'h3FC00000);
    send(0, 1'b0, 32'h40100000);
    send(0, 1'b0, 32'hBF400000);
    send(0, 1'b0, 32'h40800000);
    result(0, "max_latch", 32'h40800000);

    // Backpressure: result held 5 cycles while valid_i stays high
    rdi[0] = 1'b0;
    send(0, 1'b0, 32'h3FC00000);
    send(0, 1'b0, 32'h40100000);
    send(0, 1'b0, 32'hBF400000);
    send(0, 1'b0, 32'h40800000);
    vi[0] = 1'b1; opi[0] = 1'b0; ni[0] = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(vo[0]), 32'd1);
      chk("bp_sum", so[0], 32'h40E00000);
      chk("bp_ready", 32'(ro[0]), 32'd0);
      @(negedge clk);
    end
    rdi[0] = 1'b1;
    chk("bp_release_valid", 32'(vo[0]), 32'd1);
    chk("bp_release_ready", 32'(ro[0]), 32'd0);
    @(negedge clk);
    chk("bp_after_ready", 32'(ro[0]), 32'd1);
    chk("bp_after_valid", 32'(vo[0]), 32'd0);
    @(negedge clk);
    vi[0] = 1'b0;
    send(0, 1'b0, 32'h3F800000);
    send(0, 1'b0, 32'h3F800000);
    send(0, 1'b0, 32'h3F800000);
    result(0, "bp_next", 32'h40800000);

    // Reset mid-window discards the partial window and the concurrent sample
    send(0, 1'b0, 32'h40000000);
    send(0, 1'b0, 32'h40000000);
    reset = 1'b1; vi[0] = 1'b1; ni[0] = 32'h40000000;
    @(negedge clk);
    reset = 1'b0; vi[0] = 1'b0;
    #1;
    chk("midrst_ready", 32'(ro[0]), 32'd1);
    chk("midrst_valid", 32'(vo[0]), 32'd0);
    chk("midrst_sum", so[0], 32'd0);
    @(negedge clk);
    send(0, 1'b0, 32'h3F800000);
    send(0, 1'b0, 32'h3F800000);
    chk("midrst_early2", 32'(vo[0]), 32'd0);
    send(0, 1'b0, 32'h3F800000);
    chk("midrst_early3", 32'(vo[0]), 32'd0);
    send(0, 1'b0, 32'h3F800000);
    result(0, "midrst", 32'h40800000);

    // Rounding and special cases, WINDOW=2
    pair("tie_even",   1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000);
    pair("tie_up",     1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002);
    pair("round_bit",  1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800001);
    pair("overflow",   1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    pair("inf_minf",   1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
    pair("denorm",     1'b0, 32'h00000001, 32'h80000000, 32'h00000000);
    pair("cancel",     1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000);
    pair("negzero",    1'b0, 32'h80000000, 32'h80000000, 32'h80000000);
    pair("normalize",  1'b0, 32'h40000000, 32'hBF800001, 32'h3F7FFFFE);
    pair("one_one",    1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000);
    pair("max_zero",   1'b1, 32'h80000000, 32'h00000000, 32'h00000000);
    pair("max_nan",    1'b1, 32'h3F800000, 32'h7FA00000, 32'h7FC00000);
    pair("max_neg",    1'b1, 32'hBF800000, 32'hC0000000, 32'hBF800000);

    // WINDOW=1 pass-through after flush / NaN canonicalisation
    send(2, 1'b0, 32'h80000001);
    result(2, "w1_denorm", 32'h80000000);
    send(2, 1'b0, 32'h7F800001);
    result(2, "w1_nan", 32'h7FC00000);
    send(2, 1'b1, 32'h40490FDB);
    result(2, "w1_pass", 32'h40490FDB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
